// File: rtl/main_mem_if.sv
// Request/response handshake bundle between a requester (master) and
// main_mem_responder (slave).
interface main_mem_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_we
  );
endinterface

// File: rtl/main_mem_responder.sv
// 256x8 memory responder with fixed request-to-response latency (LATENCY cycles).
// Optional read/write statistics counters under macro MAIN_MEM_STATS_EN.
module main_mem_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic      clk,
  input  logic      rst,
  main_mem_if.slave bus
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [7:0] rd_count,
  output logic [7:0] wr_count
`endif
);
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 256;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_INIT = (LATENCY > 32'd1) ? (LATENCY - 32'd2) : 32'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_we_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept_c;
  logic              handshake_c;
  logic              enter_resp_c;
  logic              fire_we_c;
  logic [ADDR_W-1:0] fire_addr_c;
  logic [DATA_W-1:0] fire_wdata_c;

  // With LATENCY=1 the response is formed on the acceptance edge, so use the live request.
  always_comb begin
    accept_c     = (state == IDLE) && bus.req_valid;
    handshake_c  = (state == RESP) && bus.resp_ready;
    enter_resp_c = (accept_c && (LATENCY == 32'd1)) || ((state == BUSY) && (cnt == '0));
    fire_we_c    = we_q;
    fire_addr_c  = addr_q;
    fire_wdata_c = wdata_q;
    if (state == IDLE) begin
      fire_we_c    = bus.req_we;
      fire_addr_c  = bus.req_addr;
      fire_wdata_c = bus.req_wdata;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (accept_c) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (enter_resp_c) begin
        state        <= RESP;
        req_ready_q  <= 1'b0;
        resp_valid_q <= 1'b1;
        resp_we_q    <= fire_we_c;
        resp_rdata_q <= fire_we_c ? '0 : mem[fire_addr_c];
      end else begin
        case (state)
          IDLE: begin
            if (accept_c) begin
              state       <= BUSY;
              cnt         <= CNT_W'(CNT_INIT);
              req_ready_q <= 1'b0;
            end
          end
          BUSY: cnt <= cnt - CNT_W'(1);
          RESP: begin
            if (handshake_c) begin
              state        <= IDLE;
              resp_valid_q <= 1'b0;
              req_ready_q  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage: writes land only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (enter_resp_c && fire_we_c) begin
      mem[fire_addr_c] <= fire_wdata_c;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_we    = resp_we_q;
  assign bus.resp_rdata = resp_rdata_q;

`ifdef MAIN_MEM_STATS_EN
  // Saturating completion counters, bumped on the response handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (handshake_c) begin
      if (resp_we_q) begin
        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      end else begin
        if (rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_main_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  main_mem_if bus_l3 ();
  main_mem_if bus_l1 ();

  logic       drv_valid [2];
  logic       drv_we    [2];
  logic       drv_ready [2];
  logic [7:0] drv_addr  [2];
  logic [7:0] drv_wdata [2];

  assign bus_l3.req_valid  = drv_valid[0];
  assign bus_l3.req_we     = drv_we[0];
  assign bus_l3.req_addr   = drv_addr[0];
  assign bus_l3.req_wdata  = drv_wdata[0];
  assign bus_l3.resp_ready = drv_ready[0];
  assign bus_l1.req_valid  = drv_valid[1];
  assign bus_l1.req_we     = drv_we[1];
  assign bus_l1.req_addr   = drv_addr[1];
  assign bus_l1.req_wdata  = drv_wdata[1];
  assign bus_l1.resp_ready = drv_ready[1];

`ifdef MAIN_MEM_STATS_EN
  logic [7:0] rd_count [2];
  logic [7:0] wr_count [2];
  main_mem_responder #(.LATENCY(3)) u_dut_l3 (.clk(clk), .rst(rst), .bus(bus_l3),
                                              .rd_count(rd_count[0]), .wr_count(wr_count[0]));
  main_mem_responder #(.LATENCY(1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(bus_l1),
                                              .rd_count(rd_count[1]), .wr_count(wr_count[1]));
`else
  main_mem_responder #(.LATENCY(3)) u_dut_l3 (.clk(clk), .rst(rst), .bus(bus_l3));
  main_mem_responder #(.LATENCY(1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(bus_l1));
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb_q0 [$];
  exp_t       sb_q1 [$];
  logic [7:0] model_mem [2][256];
  int         n_rd [2];
  int         n_wr [2];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic req_ready_of(input int sel);
    return (sel == 0) ? bus_l3.req_ready : bus_l1.req_ready;
  endfunction
  function automatic logic resp_valid_of(input int sel);
    return (sel == 0) ? bus_l3.resp_valid : bus_l1.resp_valid;
  endfunction
  function automatic logic resp_we_of(input int sel);
    return (sel == 0) ? bus_l3.resp_we : bus_l1.resp_we;
  endfunction
  function automatic logic [7:0] rdata_of(input int sel);
    return (sel == 0) ? bus_l3.resp_rdata : bus_l1.resp_rdata;
  endfunction
  function automatic int lat_of(input int sel);
    return (sel == 0) ? 3 : 1;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 256; a++) model_mem[s][a] = 8'h00;
      n_rd[s] = 0;
      n_wr[s] = 0;
    end
    sb_q0.delete();
    sb_q1.delete();
  endtask

  // One complete transaction: issue, latency check, optional stall, handshake.
  task automatic run_txn(input int sel, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input int hold, input bit poke);
    exp_t       e;
    int         k;
    int         waited;
    logic [7:0] r0;
    logic       w0;
    waited = 0;
    while (!req_ready_of(sel) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready_of(sel)) begin
      check_eq("accept_timeout", 32'(req_ready_of(sel)), 32'd1);
      return;
    end
    drv_valid[sel] = 1'b1;
    drv_we[sel]    = we;
    drv_addr[sel]  = addr;
    drv_wdata[sel] = wdata;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = we ? 8'h00 : model_mem[sel][addr];
    if (sel == 0) sb_q0.push_back(e); else sb_q1.push_back(e);
    @(posedge clk); #1;
    drv_valid[sel] = 1'b0;
    drv_we[sel]    = ~we;
    drv_addr[sel]  = ~addr;
    drv_wdata[sel] = ~wdata;
    k = 1;
    while (!resp_valid_of(sel) && k < 20) begin
      check_eq("busy_ready", 32'(req_ready_of(sel)), 32'd0);
      if (poke) drv_valid[sel] = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check_eq("latency", 32'(k), 32'(lat_of(sel)));
    r0 = rdata_of(sel);
    w0 = resp_we_of(sel);
    for (int i = 0; i < hold; i++) begin
      if (poke) drv_valid[sel] = i[0];
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(resp_valid_of(sel)), 32'd1);
      check_eq("hold_rdata", 32'(rdata_of(sel)), 32'(r0));
      check_eq("hold_we", 32'(resp_we_of(sel)), 32'(w0));
      check_eq("hold_ready", 32'(req_ready_of(sel)), 32'd0);
    end
    drv_valid[sel] = 1'b0;
    if (sel == 0) e = sb_q0.pop_front(); else e = sb_q1.pop_front();
    check_eq("resp_valid", 32'(resp_valid_of(sel)), 32'd1);
    check_eq("resp_rdata", 32'(rdata_of(sel)), 32'(e.rdata));
    check_eq("resp_we", 32'(resp_we_of(sel)), 32'(e.we));
    if (e.we) begin
      model_mem[sel][e.addr] = e.wdata;
      if (n_wr[sel] < 255) n_wr[sel]++;
    end else begin
      if (n_rd[sel] < 255) n_rd[sel]++;
    end
    drv_ready[sel] = 1'b1;
    @(posedge clk); #1;
    drv_ready[sel] = 1'b0;
    check_eq("valid_drop", 32'(resp_valid_of(sel)), 32'd0);
    check_eq("idle_bubble", 32'(req_ready_of(sel)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    logic       w;
    for (int s = 0; s < 2; s++) begin
      drv_valid[s] = 1'b0;
      drv_we[s]    = 1'b0;
      drv_ready[s] = 1'b0;
      drv_addr[s]  = 8'h00;
      drv_wdata[s] = 8'h00;
    end
    clear_model();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_resp_valid", 32'(resp_valid_of(s)), 32'd0);
      check_eq("rst_resp_rdata", 32'(rdata_of(s)), 32'd0);
      check_eq("rst_resp_we", 32'(resp_we_of(s)), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", 32'(req_ready_of(0)), 32'd1);
    check_eq("ready_after_rst", 32'(req_ready_of(1)), 32'd1);

    run_txn(0, 1'b0, 8'hFF, 8'h00, 0, 1'b0);
    run_txn(0, 1'b1, 8'h10, 8'hA5, 0, 1'b0);
    run_txn(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    run_txn(0, 1'b0, 8'h10, 8'h00, 5, 1'b1);
    run_txn(0, 1'b1, 8'h11, 8'h3C, 5, 1'b1);
    run_txn(0, 1'b0, 8'h11, 8'h00, 2, 1'b0);

    run_txn(1, 1'b0, 8'h40, 8'h00, 0, 1'b0);
    run_txn(1, 1'b1, 8'h40, 8'h77, 0, 1'b0);
    run_txn(1, 1'b0, 8'h40, 8'h00, 0, 1'b0);
    run_txn(1, 1'b0, 8'h40, 8'h00, 0, 1'b1);
    run_txn(1, 1'b1, 8'h20, 8'hC3, 3, 1'b1);

    for (int n = 0; n < 48; n++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      run_txn(n % 2, w, a, d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef MAIN_MEM_STATS_EN
    for (int s = 0; s < 2; s++) begin
      check_eq("rd_count", 32'(rd_count[s]), 32'(n_rd[s]));
      check_eq("wr_count", 32'(wr_count[s]), 32'(n_wr[s]));
    end
`endif

    // Reset while a write is in flight: no commit, no response.
    drv_valid[0] = 1'b1;
    drv_we[0]    = 1'b1;
    drv_addr[0]  = 8'h20;
    drv_wdata[0] = 8'h5A;
    @(posedge clk); #1;
    drv_valid[0] = 1'b0;
    check_eq("abort_in_busy", 32'(req_ready_of(0)), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    check_eq("abort_ready", 32'(req_ready_of(0)), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check_eq("abort_no_resp", 32'(resp_valid_of(0)), 32'd0);
      @(posedge clk); #1;
    end
    run_txn(0, 1'b0, 8'h20, 8'h00, 0, 1'b0);
    run_txn(1, 1'b0, 8'h40, 8'h00, 0, 1'b0);
    run_txn(1, 1'b0, 8'h20, 8'h00, 0, 1'b0);

`ifdef MAIN_MEM_STATS_EN
    run_txn(1, 1'b1, 8'h05, 8'h99, 0, 1'b0);
    run_txn(1, 1'b1, 8'h06, 8'h98, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      run_txn(1, 1'b0, 8'($urandom_range(0, 7)), 8'h00, 0, 1'b0);
    end
    check_eq("rd_count_sat", 32'(rd_count[1]), 32'(n_rd[1]));
    check_eq("wr_count_kept", 32'(wr_count[1]), 32'(n_wr[1]));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
